// File: rtl/demux_1_2_buf.sv
// 1-to-2 stream demultiplexer with an independent 2-entry FIFO per output channel.
// Channel 0 is A and channel 1 is B. Each channel also counts the words routed to it.
module demux_1_2_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [15:0]      a_count,
    output logic [15:0]      b_count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state [2];
    logic [WIDTH-1:0] r_head  [2];
    logic [WIDTH-1:0] r_tail  [2];
    logic [15:0]      r_count [2];

    logic [1:0] w_out_ready;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    assign w_out_ready = {b_ready, a_ready};

    // No bypass: a FULL channel refuses input even while it pops.
    assign in_ready = (r_state[in_sel] != S_FULL);

    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            w_push[c] = in_valid && in_ready && (in_sel == c[0]);
            w_pop[c]  = (r_state[c] != S_EMPTY) && w_out_ready[c];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < 2; c++) begin
            if (rst) begin
                r_state[c] <= S_EMPTY;
                r_head[c]  <= '0;
                r_tail[c]  <= '0;
                r_count[c] <= '0;
            end else begin
                if (w_push[c]) begin
                    r_count[c] <= r_count[c] + 16'd1;
                end
                case (r_state[c])
                    S_EMPTY: begin
                        if (w_push[c]) begin
                            r_head[c]  <= in_data;
                            r_state[c] <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_push[c] && w_pop[c]) begin
                            r_head[c] <= in_data;
                        end else if (w_push[c]) begin
                            r_tail[c]  <= in_data;
                            r_state[c] <= S_FULL;
                        end else if (w_pop[c]) begin
                            r_state[c] <= S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (w_pop[c]) begin
                            r_head[c]  <= r_tail[c];
                            r_state[c] <= S_ONE;
                        end
                    end
                    default: r_state[c] <= S_EMPTY;
                endcase
            end
        end
    end

    assign a_data  = r_head[0];
    assign b_data  = r_head[1];
    assign a_valid = (r_state[0] != S_EMPTY);
    assign b_valid = (r_state[1] != S_EMPTY);
    assign a_count = r_count[0];
    assign b_count = r_count[1];

endmodule
